// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and redirect controller for the 5-stage pipeline.
// Shadows the EX/MEM/WB slots and drives the pipeline enables, the flush and
// bubble controls, the PC select and the forwarding muxes. It also sequences
// the two-cycle memory-indirect jump and keeps a saturating stall/flush
// counter.
module pipeline_hazard_ctrl #(
   parameter int unsigned REG_AW = 6,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              id_valid,
   input  logic [11:0]       id_ctrl,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic [REG_AW-1:0] id_rd,
   input  logic              id_uses_rs,
   input  logic              id_uses_rt,
   input  logic              ex_z,
   input  logic              ex_n,
   output logic              pc_write,
   output logic              ifid_write,
   output logic              ifid_flush,
   output logic              idex_bubble,
   output logic [1:0]        pc_sel,
   output logic [1:0]        fwd_a,
   output logic [1:0]        fwd_b,
   output logic [CNT_W-1:0]  stall_count
);

   typedef struct packed {
      logic              valid;
      logic [REG_AW-1:0] rd;
      logic [REG_AW-1:0] rs;
      logic [REG_AW-1:0] rt;
      logic              regwrite;
      logic              memread;
      logic              jump;
      logic              jump_mem;
      logic              brz;
      logic              brn;
   } slot_t;

   typedef enum logic [0:0] {st_run, st_jm_mem} state_t;

   slot_t  id_slot, ex_q, mem_q, wb_q;
   state_t state_q, state_d;
   logic   taken, load_use, jm_start;

   // Fields that only matter while an instruction is still ahead of WB.
   logic unused_bits;
   assign unused_bits = ^{id_ctrl[11:9], id_ctrl[7], id_ctrl[5:4], wb_q.rs, wb_q.rt,
                          wb_q.memread, wb_q.jump, wb_q.jump_mem, wb_q.brz, wb_q.brn};

   // Candidate EX slot built from the ID-stage decode.
   always_comb begin
      id_slot          = '0;
      id_slot.valid    = id_valid & ~idex_bubble;
      id_slot.rd       = id_rd;
      id_slot.rs       = id_rs;
      id_slot.rt       = id_rt;
      id_slot.regwrite = id_ctrl[6];
      id_slot.memread  = id_ctrl[8];
      id_slot.jump     = id_ctrl[1];
      id_slot.jump_mem = id_ctrl[0];
      id_slot.brz      = id_ctrl[3];
      id_slot.brn      = id_ctrl[2];
   end

   // Shadow pipeline advance and JM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         ex_q    <= '0;
         mem_q   <= '0;
         wb_q    <= '0;
         state_q <= st_run;
      end else begin
         ex_q    <= id_slot;
         mem_q   <= ex_q;
         wb_q    <= mem_q;
         state_q <= state_d;
      end
   end

   assign taken    = ex_q.valid & (ex_q.jump | (ex_q.brz & ex_z) | (ex_q.brn & ex_n));
   assign jm_start = (state_q == st_run) & ex_q.valid & ex_q.jump_mem;
   assign load_use = ex_q.valid & ex_q.memread &
                     ((id_uses_rs & (id_rs == ex_q.rd)) | (id_uses_rt & (id_rt == ex_q.rd)));

   // Next state and pipeline controls; JM beats redirect beats load-use.
   // Outputs are held at reset values while rst is high so an aborted JM
   // never issues its memory-target select.
   always_comb begin
      state_d     = state_q;
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      pc_sel      = 2'b00;
      if (rst) begin
         state_d = st_run;
      end else if (state_q == st_jm_mem) begin
         pc_sel      = 2'b10;
         ifid_flush  = 1'b1;
         idex_bubble = 1'b1;
         state_d     = st_run;
      end else if (jm_start) begin
         pc_write    = 1'b0;
         ifid_flush  = 1'b1;
         idex_bubble = 1'b1;
         state_d     = st_jm_mem;
      end else if (taken) begin
         pc_sel      = 2'b01;
         ifid_flush  = 1'b1;
         idex_bubble = 1'b1;
      end else if (load_use) begin
         pc_write    = 1'b0;
         ifid_write  = 1'b0;
         idex_bubble = 1'b1;
      end
   end

   // Operand forwarding; a load in MEM has no data yet, so only WB serves it.
   always_comb begin
      fwd_a = 2'b00;
      fwd_b = 2'b00;
      if (!rst) begin
         if (mem_q.valid & mem_q.regwrite & ~mem_q.memread & (mem_q.rd == ex_q.rs)) begin
            fwd_a = 2'b01;
         end else if (wb_q.valid & wb_q.regwrite & (wb_q.rd == ex_q.rs)) begin
            fwd_a = 2'b10;
         end
         if (mem_q.valid & mem_q.regwrite & ~mem_q.memread & (mem_q.rd == ex_q.rt)) begin
            fwd_b = 2'b01;
         end else if (wb_q.valid & wb_q.regwrite & (wb_q.rd == ex_q.rt)) begin
            fwd_b = 2'b10;
         end
      end
   end

   // Saturating count of stalled or flushing cycles.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_count <= '0;
      end else if ((~pc_write | ifid_flush) && (stall_count != {CNT_W{1'b1}})) begin
         stall_count <= stall_count + 1'b1;
      end
   end

endmodule
